// File: rtl/poly_decompress_ctrl_if.sv
// poly_decompress_ctrl_if: source read (rd_*), decompress pipe (dec_in/dec_out) and sink write (wr_*) bundle; master = controller
interface poly_decompress_ctrl_if #(
    parameter int D = 4,
    parameter int N = 256
);
    localparam int AW = N > 1 ? $clog2(N) : 1;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [D-1:0]  rd_data;
    logic [D-1:0]  dec_in;
    logic [11:0]   dec_out;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [11:0]   wr_data;
    modport master (
        output rd_en, rd_addr, dec_in, wr_valid, wr_addr, wr_data,
        input  rd_data, dec_out, wr_ready
    );
    modport slave (
        input  rd_en, rd_addr, dec_in, wr_valid, wr_addr, wr_data,
        output rd_data, dec_out, wr_ready
    );
endinterface

// File: rtl/poly_decompress_ctrl.sv
// poly_decompress_ctrl: Kyber decompress sequencer; start/busy/done control, bus carries source reads, decompress pipe and sink writes
module poly_decompress_ctrl #(
    parameter int D          = 4,
    parameter int N          = 256,
    parameter int LAT        = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    poly_decompress_ctrl_if.master bus
);
    localparam int AW = N > 1 ? $clog2(N) : 1;
    localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_n;
    logic ld;
    logic [D-1:0] hold;
    logic [LAT-1:0] tag;
    logic [CW-1:0] inflight, count;
    logic [PW-1:0] wp, rp;
    logic [11:0] mem [FIFO_DEPTH];
    logic push, pop;
    assign push = tag[LAT-1];
    assign pop = bus.wr_valid && bus.wr_ready;
    assign bus.dec_in = ld ? bus.rd_data : hold;
    assign bus.wr_valid = count != '0;
    assign bus.wr_data = bus.wr_valid ? mem[rp] : 12'd0;
    always_ff @(posedge clk)
        state <= !rst_n ? IDLE : state_n;
    always_comb begin
        busy = state != IDLE;
        done = state == DONE;
        bus.rd_en = state == RUN && !ld && 32'(inflight) + 32'(count) < FIFO_DEPTH;
        state_n = state == IDLE  ? (start ? RUN : IDLE)
                : state == RUN   ? (bus.rd_en && bus.rd_addr == AW'(N - 1) ? DRAIN : RUN)
                : state == DRAIN ? (pop && bus.wr_addr == AW'(N - 1) ? DONE : DRAIN)
                : IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n || state == IDLE) begin
            ld          <= 1'b0;
            hold        <= '0;
            tag         <= '0;
            inflight    <= '0;
            count       <= '0;
            wp          <= '0;
            rp          <= '0;
            bus.rd_addr <= '0;
            bus.wr_addr <= '0;
        end else begin
            ld       <= bus.rd_en;
            tag      <= LAT'({tag, ld});
            inflight <= inflight + CW'(bus.rd_en) - CW'(push);
            count    <= count + CW'(push) - CW'(pop);
            if (ld) hold <= bus.rd_data;
            if (push) wp <= wp == PW'(FIFO_DEPTH - 1) ? '0 : wp + 1'b1;
            if (pop) rp <= rp == PW'(FIFO_DEPTH - 1) ? '0 : rp + 1'b1;
            if (bus.rd_en) bus.rd_addr <= bus.rd_addr + 1'b1;
            if (pop) bus.wr_addr <= bus.wr_addr + 1'b1;
        end
    end
    always_ff @(posedge clk)
        if (push) mem[wp] <= bus.dec_out;
    assert property (@(posedge clk) disable iff (!rst_n) !(push && count == CW'(FIFO_DEPTH)));
endmodule
